// File: rtl/midori64_pkg.sv
// Shared Midori64 constants, FSM encoding and cell-level helpers.
// Cell i of a 64-bit state occupies bits [63-4i -: 4]; the state is column-major, with 16 bits per column.
package midori64_pkg;

  localparam int NR = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] SBOX0 [16] = '{
    4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
    4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
  };

  localparam int SHUF_P [16] = '{
    0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8
  };

  // Bit j of each constant, counted from the left of the hex value, belongs to cell j.
  localparam logic [0:15] BETA [15] = '{
    16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
    16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
    16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90
  };

  function automatic logic [63:0] sc64(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[63-4*i -: 4] = SBOX0[s[63-4*i -: 4]];
    end
    return r;
  endfunction

  function automatic logic [63:0] sr64(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[63-4*i -: 4] = s[63-4*SHUF_P[i] -: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] beta64(input logic [3:0] rnd);
    logic [63:0] r;
    logic [0:15] b;
    r = '0;
    b = (rnd < 4'd15) ? BETA[rnd] : '0;
    for (int j = 0; j < 16; j++) begin
      r[60-4*j] = b[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/midori64_round.sv
// One combinational Midori64 round: SubCell, ShuffleCell, MixColumn, then round-key add.
module midori64_round
  import midori64_pkg::*;
(
  input  logic [63:0] i_state,
  input  logic [63:0] i_rk64,
  output logic [63:0] o_state
);

  logic [63:0] w_sr;
  logic [63:0] w_mc;

  assign w_sr = sr64(sc64(i_state));

  // MixColumn: XORing the whole column into a cell cancels that cell, which leaves the XOR of the other three.
  always_comb begin
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        w_mc[63-16*c-4*k -: 4] = w_sr[63-16*c -: 4] ^ w_sr[59-16*c -: 4]
                               ^ w_sr[55-16*c -: 4] ^ w_sr[51-16*c -: 4]
                               ^ w_sr[63-16*c-4*k -: 4];
      end
    end
  end

  assign o_state = w_mc ^ i_rk64;

endmodule

// File: rtl/midori64_enc_ctrl.sv
// Round-iterative Midori64 encryption controller: 15 full rounds plus a final SubCell/whitening step.
// A block is accepted in IDLE, and the ciphertext is offered in DONE with a valid/ready handshake.
module midori64_enc_ctrl
  import midori64_pkg::*;
#(
  parameter int NR       = 16,
  parameter bit OUT_HOLD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  ct,
  output logic         busy
);

  if (NR != midori64_pkg::NR) begin : g_bad_nr
    $error("midori64_enc_ctrl: NR must equal midori64_pkg::NR");
  end

  localparam logic [3:0] LAST_RND = 4'(midori64_pkg::NR - 2);

  state_e       r_fsm;
  state_e       w_fsm_next;
  logic [63:0]  r_state;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;
  logic [63:0]  r_ct;
  logic [63:0]  w_wk;
  logic [63:0]  w_rk64;
  logic [63:0]  w_round_out;
  logic [63:0]  w_final;

  assign w_wk    = r_key[127:64] ^ r_key[63:0];
  assign w_rk64  = (r_rnd[0] ? r_key[63:0] : r_key[127:64]) ^ beta64(r_rnd);
  assign w_final = sc64(r_state) ^ w_wk;

  midori64_round u_round (
    .i_state (r_state),
    .i_rk64  (w_rk64),
    .o_state (w_round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = IDLE;
    case (r_fsm)
      IDLE:    w_fsm_next = in_valid ? ROUND : IDLE;
      ROUND:   w_fsm_next = (r_rnd == LAST_RND) ? FINAL : ROUND;
      FINAL:   w_fsm_next = DONE;
      DONE:    w_fsm_next = (!OUT_HOLD || out_ready) ? IDLE : DONE;
      default: w_fsm_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_fsm == IDLE);
    out_valid = (r_fsm == DONE);
    busy      = (r_fsm == ROUND) || (r_fsm == FINAL);
  end

  // rnd holds at the last round index, so 15 is never reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
      r_ct    <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_key   <= key;
            r_state <= pt ^ key[127:64] ^ key[63:0];
            r_rnd   <= '0;
          end
        end
        ROUND: begin
          r_state <= w_round_out;
          if (r_rnd != LAST_RND) begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        FINAL: begin
          r_state <= w_final;
          r_ct    <= w_final;
        end
        default: begin
        end
      endcase
    end
  end

  assign ct = r_ct;

endmodule

// File: tb/tb_midori64_enc_ctrl.sv
// Directed-vector bench for midori64_enc_ctrl (OUT_HOLD = 1) using published Midori64 test vectors.
module tb_midori64_enc_ctrl;

  localparam logic [127:0] KEY_A = 128'h0;
  localparam logic [63:0]  PT_A  = 64'h0;
  localparam logic [63:0]  CT_A  = 64'h3c9cceda2bbd449a;
  localparam logic [127:0] KEY_B = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
  localparam logic [63:0]  PT_B  = 64'h42c20fd3b586879e;
  localparam logic [63:0]  CT_B  = 64'h66bcdc6270d901cd;
  localparam logic [63:0]  PT_X  = 64'hdeadbeefcafef00d;

  logic         clk;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [63:0]  ptIn;
  logic [127:0] keyIn;
  logic         outValid;
  logic         outReady;
  logic [63:0]  ctOut;
  logic         busyOut;

  int total;
  int bad;

  midori64_enc_ctrl #(.NR(16), .OUT_HOLD(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .pt        (ptIn),
    .key       (keyIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .ct        (ctOut),
    .busy      (busyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic startBlock(input logic [63:0] p, input logic [127:0] k);
    inValid = 1'b1;
    ptIn    = p;
    keyIn   = k;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic waitOut(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (outValid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0; ptIn = '0; keyIn = '0;
    #3;
    total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", inReady); end
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", outValid); end
    total++; if (busyOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busyOut); end
    total++; if (ctOut !== 64'h0) begin bad++; $display("[TB] FAIL reset_ct got=%h want=0", ctOut); end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_vector();
    int lat;
    outReady = 1'b1;
    startBlock(PT_A, KEY_A);
    total++; if (busyOut !== 1'b1) begin bad++; $display("[TB] FAIL zero_busy got=%b want=1", busyOut); end
    total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL zero_in_ready got=%b want=0", inReady); end
    waitOut(lat);
    total++; if (lat !== 16) begin bad++; $display("[TB] FAIL zero_latency got=%0d want=16", lat); end
    total++; if (ctOut !== CT_A) begin bad++; $display("[TB] FAIL zero_ct got=%h want=%h", ctOut, CT_A); end
    @(posedge clk); #1;
    total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL zero_idle_in_ready got=%b want=1", inReady); end
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL zero_idle_out_valid got=%b want=0", outValid); end
  endtask

  task automatic test_standard_vector();
    int lat;
    outReady = 1'b1;
    startBlock(PT_B, KEY_B);
    waitOut(lat);
    total++; if (lat !== 16) begin bad++; $display("[TB] FAIL std_latency got=%0d want=16", lat); end
    total++; if (ctOut !== CT_B) begin bad++; $display("[TB] FAIL std_ct got=%h want=%h", ctOut, CT_B); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    outReady = 1'b0;
    startBlock(PT_A, KEY_A);
    waitOut(lat);
    total++; if (lat !== 16) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=16", lat); end
    total++; if (ctOut !== CT_A) begin bad++; $display("[TB] FAIL bp_ct got=%h want=%h", ctOut, CT_A); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid cyc=%0d got=%b want=1", c, outValid); end
      total++; if (ctOut !== CT_A) begin bad++; $display("[TB] FAIL bp_hold_ct cyc=%0d got=%h want=%h", c, ctOut, CT_A); end
      total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_in_ready cyc=%0d got=%b want=0", c, inReady); end
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_in_ready got=%b want=1", inReady); end
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_out_valid got=%b want=0", outValid); end
  endtask

  task automatic test_ignored_input();
    int nOut;
    int firstAt;
    logic [63:0] firstCt;
    nOut = 0; firstAt = -1; firstCt = '0;
    outReady = 1'b1;
    startBlock(PT_B, KEY_B);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      inValid = (k == 2 || k == 9);
      ptIn    = PT_X;
      if (outValid === 1'b1) begin
        if (nOut == 0) begin
          firstAt = k;
          firstCt = ctOut;
        end
        nOut++;
      end
    end
    inValid = 1'b0;
    total++; if (nOut !== 1) begin bad++; $display("[TB] FAIL ign_out_count got=%0d want=1", nOut); end
    total++; if (firstAt !== 16) begin bad++; $display("[TB] FAIL ign_latency got=%0d want=16", firstAt); end
    total++; if (firstCt !== CT_B) begin bad++; $display("[TB] FAIL ign_ct got=%h want=%h", firstCt, CT_B); end
  endtask

  task automatic test_async_reset();
    int lat;
    outReady = 1'b1;
    startBlock(PT_B, KEY_B);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    #2;
    total++; if (busyOut !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre_busy got=%b want=1", busyOut); end
    rstN = 1'b0;
    #1;
    total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL arst_in_ready got=%b want=1", inReady); end
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL arst_out_valid got=%b want=0", outValid); end
    total++; if (busyOut !== 1'b0) begin bad++; $display("[TB] FAIL arst_busy got=%b want=0", busyOut); end
    total++; if (ctOut !== 64'h0) begin bad++; $display("[TB] FAIL arst_ct got=%h want=0", ctOut); end
    @(posedge clk); #1;
    rstN = 1'b1;
    startBlock(PT_A, KEY_A);
    waitOut(lat);
    total++; if (lat !== 16) begin bad++; $display("[TB] FAIL arst_after_latency got=%0d want=16", lat); end
    total++; if (ctOut !== CT_A) begin bad++; $display("[TB] FAIL arst_after_ct got=%h want=%h", ctOut, CT_A); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int xferAt [2];
    int outAt [2];
    logic [63:0] outCt [2];
    int nXfer;
    int nOut;
    logic xferNow;
    nXfer = 0; nOut = 0;
    xferAt = '{-1, -1}; outAt = '{-1, -1}; outCt = '{64'h0, 64'h0};
    outReady = 1'b1;
    inValid  = 1'b1;
    ptIn     = PT_A;
    keyIn    = KEY_A;
    for (int e = 1; e <= 60; e++) begin
      xferNow = inValid && inReady;
      @(posedge clk); #1;
      if (xferNow && nXfer < 2) begin
        xferAt[nXfer] = e;
        nXfer++;
        if (nXfer == 1) begin
          ptIn  = PT_B;
          keyIn = KEY_B;
        end else begin
          inValid = 1'b0;
        end
      end
      if (outValid === 1'b1) begin
        if (nOut < 2) begin
          outAt[nOut] = e;
          outCt[nOut] = ctOut;
        end
        nOut++;
      end
    end
    inValid = 1'b0;
    total++; if (nXfer !== 2) begin bad++; $display("[TB] FAIL b2b_xfer_count got=%0d want=2", nXfer); end
    total++; if (xferAt[1] - xferAt[0] !== 18) begin bad++; $display("[TB] FAIL b2b_xfer_gap got=%0d want=18", xferAt[1] - xferAt[0]); end
    total++; if (nOut !== 2) begin bad++; $display("[TB] FAIL b2b_out_count got=%0d want=2", nOut); end
    total++; if (outAt[0] - xferAt[0] !== 16) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=16", outAt[0] - xferAt[0]); end
    total++; if (outCt[0] !== CT_A) begin bad++; $display("[TB] FAIL b2b_ct0 got=%h want=%h", outCt[0], CT_A); end
    total++; if (outCt[1] !== CT_B) begin bad++; $display("[TB] FAIL b2b_ct1 got=%h want=%h", outCt[1], CT_B); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero_vector();
    test_standard_vector();
    test_backpressure();
    test_ignored_input();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midori64_enc_ctrl.md
Name: midori64_enc_ctrl

Overview:
- Round-iterative Midori64 encryption controller: one round per clock, 16 cycles per block.
- Sequences a single combinational round datapath (SubCell, ShuffleCell, the existing MixColumn block, key/constant add).
- Holds state and round counter; exposes valid/ready handshakes on input and output.
- Reference-model core for the team's shared Midori64 datapaths; unmasked.

Parameters:
- NR, 16, total rounds; fixed by Midori64; parameter exists only for the package constant check.
- OUT_HOLD, 1, 1 = hold ciphertext until out_ready; 0 = out_valid is a single-cycle pulse.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  controller can accept a block
- pt  in  64  plaintext; cell 0 = bits 63:60
- key  in  128  K0 = key[127:64], K1 = key[63:0]
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- ct  out  64  ciphertext
- busy  out  1  high in ROUND or FINAL

Behaviour:
- Reset (async, rst_n low): FSM = IDLE, state = 0, key_reg = 0, rnd = 0, out_valid = 0, in_ready = 1, busy = 0, ct = 0. Reset mid-operation aborts the block; no output is produced for it.
- Transfer in: the cycle where in_valid && in_ready. On that edge: key_reg <= key; state <= pt ^ WK, where WK = K0 ^ K1; rnd <= 0; FSM -> ROUND.
- ROUND: each edge does state <= MC(SR(SC(state))) ^ K[rnd mod 2] ^ beta(rnd), then rnd <= rnd + 1.
  - rnd == 14 -> FSM FINAL.
  - beta(i) is a 16-bit constant from the package; bit j is XORed into the LSB of cell j (bit 60 - 4j).
- FINAL: one edge does state <= SC(state) ^ WK; FSM -> DONE.
- Latency: transfer in at edge 0; out_valid = 1 after edge 16.
- DONE: ct = state, out_valid = 1.
  - OUT_HOLD = 1: hold ct and out_valid until out_ready is high at an edge, then go to IDLE.
  - OUT_HOLD = 0: leave DONE after one cycle regardless of out_ready.
- in_ready = 1 only in IDLE. in_valid outside IDLE is ignored and not queued. pt and key are sampled only at transfer.
- In DONE, a simultaneous out_ready and in_valid does not accept; the new block is accepted in the following IDLE cycle (min 18 cycles between transfers).
- rnd is 4 bits and never wraps within a block; values 15 and above are unreachable. An unreachable FSM encoding goes to IDLE.
- SC: Sb0 = {C,A,D,3,E,B,F,7,8,9,1,5,0,2,4,6}, applied per cell.
- SR: out cell i = in cell P[i], P = {0,10,5,15,14,4,11,1,9,3,12,6,7,13,2,8}.
- MC: per 16-bit column, out cell = XOR of the other three cells of the same column.
- ct is registered; key_reg is stable for the whole block.

Decomposition:
- Package midori64_pkg:
  - SBOX0[16]
  - SHUF_P[16]
  - BETA[15] (the Midori64 round constants from the specification)
  - NR = 16
  - FSM encoding: IDLE, ROUND, FINAL, DONE
  - functions sc64 and sr64
- Sub-module midori64_round: combinational SC -> SR -> midori_MC -> XOR with rk64. The controller builds rk64 from key_reg, rnd and BETA.
- The controller instantiates midori64_round once and computes FINAL with sc64 directly.

Test Plan:
- Zero vector: key = 0, pt = 0 -> ct = 3c9cceda2bbd449a, out_valid exactly 16 cycles after transfer.
- Standard vector: key = 687ded3b3c85b3f35b1009863e2a8cbf, pt = 42c20fd3b586879e -> ct = 66bcdc6270d901cd.
- Backpressure (OUT_HOLD = 1): hold out_ready = 0 for 5 cycles -> ct/out_valid stable, in_ready = 0; release -> IDLE next cycle, in_ready = 1.
- Ignored input: pulse in_valid with a different pt at cycles 3 and 10 of a block -> ct unchanged from the first vector, no second output.
- Async reset: assert rst_n = 0 at round 7 -> all outputs immediately at reset values. After release, a new zero-vector block gives 3c9cceda2bbd449a.
- Back-to-back: in_valid held high with both vectors, out_ready = 1 -> two correct cts in order, transfers 18 cycles apart.
